// File: rtl/approx_div_pkg.sv
// approx_div_pkg: shared FSM state type and subtractor cell functions for approx_seq_divider.
//   exact_sub_cell  : full subtractor, returns {diff, bout}
//   approx_sub_cell : approximate subtractor (diff = x, bout = ~x & ~bin), returns {diff, bout}
package approx_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    function automatic logic [1:0] exact_sub_cell(input logic x, input logic y, input logic bin);
        return {x ^ y ^ bin, (~x & y) | (~(x ^ y) & bin)};
    endfunction

    function automatic logic [1:0] approx_sub_cell(input logic x, input logic bin);
        return {x, ~x & ~bin};
    endfunction

endpackage

// File: rtl/approx_div_row.sv
// approx_div_row: one combinational restoring-divider row.
//   i_p      : partial remainder (N+1 bits)
//   i_d      : divisor
//   i_approx : 1 selects approximate cells for every column
//   o_qbit   : quotient bit of this row
//   o_rem    : restored or subtracted remainder
module approx_div_row
    import approx_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0]   i_p,
    input  logic [N-1:0] i_d,
    input  logic         i_approx,
    output logic         o_qbit,
    output logic [N-1:0] o_rem
);

    logic [N:0]   w_b;
    logic [N-1:0] w_diff;

    assign w_b[0] = 1'b0;

    for (genvar g = 0; g < N; g++) begin : g_col
        assign {w_diff[g], w_b[g+1]} = i_approx ? approx_sub_cell(i_p[g], w_b[g])
                                                : exact_sub_cell(i_p[g], i_d[g], w_b[g]);
    end

    assign o_qbit = i_p[N] | ~w_b[N];
    assign o_rem  = o_qbit ? w_diff : i_p[N-1:0];

endmodule

// File: rtl/approx_seq_divider.sv
// approx_seq_divider: iterative restoring divider, one row per clock, with switchable approximate low rows.
//   i_in_valid/o_in_ready   : operand handshake (ready only in IDLE)
//   i_n (2N), i_d (N)       : dividend, divisor
//   i_approx_en             : use approximate cells in rows 0..APPROX_ROWS-1
//   o_out_valid/i_out_ready : result handshake
//   o_q, o_r                : quotient, remainder
//   o_dz, o_ovf             : divisor zero, quotient does not fit in N bits
module approx_seq_divider
    import approx_div_pkg::*;
#(
    parameter int N           = 8,
    parameter int APPROX_ROWS = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [2*N-1:0] i_n,
    input  logic [N-1:0]   i_d,
    input  logic           i_approx_en,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [N-1:0]   o_q,
    output logic [N-1:0]   o_r,
    output logic           o_dz,
    output logic           o_ovf
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t          r_state, w_state_next;
    logic [N:0]      r_p;
    logic [N-1:0]    r_d, r_nlo, r_q, r_r;
    logic [IW-1:0]   r_idx;
    logic            r_approx, r_dz, r_ovf;
    logic            w_accept, w_row_approx, w_qbit;
    logic [N-1:0]    w_rem;

    assign w_accept     = i_in_valid && (r_state == S_IDLE);
    assign w_row_approx = r_approx && (32'(r_idx) < APPROX_ROWS);

    approx_div_row #(.N(N)) u_row (
        .i_p      (r_p),
        .i_d      (r_d),
        .i_approx (w_row_approx),
        .o_qbit   (w_qbit),
        .o_rem    (w_rem)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = i_in_valid ? S_BUSY : S_IDLE;
            S_BUSY:  w_state_next = (r_idx == '0) ? S_DONE : S_BUSY;
            S_DONE:  w_state_next = i_out_ready ? S_IDLE : S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_d      <= '0;
            r_nlo    <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_idx    <= '0;
            r_approx <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_p      <= i_n[2*N-1:N-1];
                r_d      <= i_d;
                r_nlo    <= i_n[N-1:0];
                r_q      <= '0;
                r_idx    <= IW'(N - 1);
                r_approx <= i_approx_en;
                r_dz     <= (i_d == '0);
                r_ovf    <= (i_n[2*N-1:N] >= i_d);
            end else if (r_state == S_BUSY) begin
                r_q[r_idx] <= w_qbit;
                r_idx      <= r_idx - 1'b1;
                // On the last row the shifted-in bit is meaningless; P is not used again.
                r_p        <= {w_rem, r_nlo[r_idx - 1'b1]};
                if (r_idx == '0) r_r <= w_rem;
            end
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_q         = r_q;
    assign o_r         = r_r;
    assign o_dz        = r_dz;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_approx_seq_divider.sv
// tb_approx_seq_divider: scoreboard-based self-checking bench for approx_seq_divider (N=8, APPROX_ROWS=2).
module tb_approx_seq_divider;

    localparam int N  = 8;
    localparam int AR = 2;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, approx_en, out_valid, out_ready, dz, ovf;
    logic [15:0] n;
    logic [7:0]  d, q, r;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    approx_seq_divider #(.N(N), .APPROX_ROWS(AR)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_n         (n),
        .i_d         (d),
        .i_approx_en (approx_en),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_q         (q),
        .o_r         (r),
        .o_dz        (dz),
        .o_ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [15:0] nn, input logic [7:0] dd, input bit a);
        res_t       res;
        int         p;
        logic [7:0] rem;
        bit         qb, b;
        p = int'(nn[15:7]);
        res.q = '0;
        rem = '0;
        for (int i = 7; i >= 0; i--) begin
            if (a && i < AR) begin
                b = 1'b0;
                for (int j = 0; j < 8; j++) b = ~p[j] & ~b;
                qb  = p[8] | ~b;
                rem = p[7:0];
            end else begin
                qb  = (p >= int'(dd));
                rem = qb ? 8'(p - int'(dd)) : p[7:0];
            end
            res.q[i] = qb;
            if (i > 0) p = int'({rem, nn[i-1]});
        end
        res.r   = rem;
        res.dz  = (dd == 8'd0);
        res.ovf = (nn[15:8] >= dd);
        return res;
    endfunction

    // Caller is at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [15:0] nn, input logic [7:0] dd, input bit a);
        bit done = 1'b0;
        n = nn; d = dd; approx_en = a; in_valid = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            if (in_ready) begin
                @(negedge clk);
                acc_cyc = cyc;
                done = 1'b1;
            end else @(negedge clk);
        end
        in_valid = 1'b0;
        if (done) sb.push_back(model(nn, dd, a));
        else begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout in_ready got 0 want 1");
        end
    endtask

    task automatic collect(output res_t got, output int lat, output bit ok);
        ok = 1'b0;
        got = '0;
        lat = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (out_valid) begin
                got = '{q, r, dz, ovf};
                lat = cyc - acc_cyc;
                ok = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL collect_timeout out_valid got 0 want 1");
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; n = '0; d = '0; approx_en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, q, r, dz, ovf} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b want 1 0 00 00 0 0",
                     in_ready, out_valid, q, r, dz, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL post_reset got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_exact;
        res_t g, e; int lat; bit ok;
        issue(16'd1000, 8'd7, 1'b0);
        collect(g, lat, ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if (g !== e || g !== res_t'{8'd142, 8'd6, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL exact got q=%0d r=%0d dz=%b ovf=%b want q=142 r=6 dz=0 ovf=0", g.q, g.r, g.dz, g.ovf);
            end
            n_cmp++;
            if (lat !== N) begin
                n_bad++;
                $display("FAIL latency got %0d want %0d", lat, N);
            end
        end
    endtask

    task automatic test_approx;
        res_t g, e; int lat; bit ok;
        issue(16'd1000, 8'd7, 1'b1);
        collect(g, lat, ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if (g !== e || g !== res_t'{8'd142, 8'd20, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL approx got q=%0d r=%0d dz=%b ovf=%b want q=142 r=20 dz=0 ovf=0", g.q, g.r, g.dz, g.ovf);
            end
        end
    endtask

    task automatic test_div_zero;
        res_t g, e; int lat; bit ok;
        issue(16'h1234, 8'h00, 1'b0);
        collect(g, lat, ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if (g !== e || g !== res_t'{8'hFF, 8'h34, 1'b1, 1'b1}) begin
                n_bad++;
                $display("FAIL div_zero got q=%h r=%h dz=%b ovf=%b want q=ff r=34 dz=1 ovf=1", g.q, g.r, g.dz, g.ovf);
            end
        end
    endtask

    task automatic test_overflow;
        res_t g, e; int lat; bit ok;
        issue(16'h0900, 8'h08, 1'b0);
        collect(g, lat, ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if (g !== e || g.ovf !== 1'b1 || g.dz !== 1'b0) begin
                n_bad++;
                $display("FAIL overflow got q=%h r=%h dz=%b ovf=%b want q=%h r=%h dz=0 ovf=1", g.q, g.r, g.dz, g.ovf, e.q, e.r);
            end
        end
    endtask

    task automatic test_backpressure;
        res_t g, e; int lat; bit ok; int c0; bit seen = 1'b0;
        issue(16'd1000, 8'd7, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL bp_wait out_valid got 0 want 1");
            void'(sb.pop_front());
            return;
        end
        g = '{q, r, dz, ovf};
        e = sb.pop_front();
        if (g !== e) begin
            n_bad++;
            $display("FAIL bp_result got q=%0d r=%0d want q=%0d r=%0d", g.q, g.r, e.q, e.r);
        end
        for (int k = 0; k < 5; k++) begin
            n = 16'h0300; d = 8'd3; in_valid = k[0];
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, q, r, dz, ovf} !== {1'b1, 1'b0, g.q, g.r, g.dz, g.ovf}) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b q=%0d r=%0d want 1 0 q=%0d r=%0d",
                         k, out_valid, in_ready, q, r, g.q, g.r);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        c0 = cyc;
        issue(16'd500, 8'd9, 1'b0);
        n_cmp++;
        if (acc_cyc !== c0 + 1) begin
            n_bad++;
            $display("FAIL bp_next_accept got delay %0d want 1", acc_cyc - c0);
        end
        collect(g, lat, ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL bp_next got q=%0d r=%0d want q=%0d r=%0d", g.q, g.r, e.q, e.r);
            end
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen || sb.size() != 0) begin
            n_bad++;
            $display("FAIL bp_ignored got spurious activity=%b pending=%0d want 0 0", seen, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        res_t g, e; int lat; bit ok; bit seen = 1'b0;
        issue(16'h1234, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        n_cmp++;
        if ({out_valid, in_ready, q, r, dz, ovf} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid got vld=%b rdy=%b q=%h r=%h dz=%b ovf=%b want 0 1 00 00 0 0",
                     out_valid, in_ready, q, r, dz, ovf);
        end
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_abort got out_valid 1 want 0");
        end
        issue(16'd1000, 8'd7, 1'b0);
        collect(g, lat, ok);
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if (g !== e || g !== res_t'{8'd142, 8'd6, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_fresh got q=%0d r=%0d want q=142 r=6", g.q, g.r);
            end
        end
    endtask

    task automatic test_back_to_back;
        res_t g, e; int lat; bit ok; int prev = -1;
        for (int k = 0; k < 10; k++) begin
            issue(16'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if (prev >= 0) begin
                n_cmp++;
                if (acc_cyc - prev !== N + 2) begin
                    n_bad++;
                    $display("FAIL b2b_interval got %0d want %0d", acc_cyc - prev, N + 2);
                end
            end
            prev = acc_cyc;
            collect(g, lat, ok);
            if (ok) begin
                e = sb.pop_front();
                n_cmp++;
                if (g !== e || lat !== N) begin
                    n_bad++;
                    $display("FAIL b2b_%0d got q=%h r=%h dz=%b ovf=%b lat=%0d want q=%h r=%h dz=%b ovf=%b lat=%0d",
                             k, g.q, g.r, g.dz, g.ovf, lat, e.q, e.r, e.dz, e.ovf, N);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
